// File: rtl/fp_multiplier_pipe.sv
// fp_multiplier_pipe: pipelined floating-point multiplier with valid/ready
// flow control, round-to-nearest-even (or truncation) and exception flags.
// Subnormal inputs are flushed to zero and no subnormal result is produced.
//
// The arithmetic is split into three phases (classify/multiply,
// normalise/guard-sticky, round/range/pack). Each phase is mapped onto one of
// the STAGES register slots. With fewer than three slots, phases share a slot.
// With four slots, the last slot is a pure retiming register. Because the
// same phase functions are used for every depth, the result is bit-identical
// for all STAGES values.
module fp_multiplier_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3,
  parameter int RNE    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  input  logic [15:0]                in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       result,
  output logic [15:0]                out_tag,
  output logic [3:0]                 flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW1  = MAN_W + 1;
  localparam int PW   = 2 * MW1;
  localparam int EW2  = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  // Slot index (0-based) that hosts each arithmetic phase.
  localparam int PH1_SLOT = 0;
  localparam int PH2_SLOT = (STAGES >= 2) ? 1 : 0;
  localparam int PH3_SLOT = (STAGES >= 3) ? 2 : STAGES - 1;

  localparam logic signed [EW2-1:0] EXP_BIAS = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] EXP_SAT  = EW2'((1 << EXP_W) - 1);

  // Everything a slot may carry. Fields not needed after a phase are simply
  // left to be trimmed by synthesis.
  typedef struct packed {
    logic                  valid;
    logic [15:0]           tag;
    logic [W-1:0]          a;
    logic [W-1:0]          b;
    logic                  sign;
    logic                  special;
    logic                  spec_invalid;
    logic [W-1:0]          spec_res;
    logic [PW-1:0]         prod;
    logic signed [EW2-1:0] expo;
    logic [MAN_W-1:0]      man;
    logic                  guard;
    logic                  sticky;
    logic [W-1:0]          res;
    logic [3:0]            flg;
  } pipe_t;

  // Phase 1: classify operands, multiply significands, add exponents.
  function automatic pipe_t f_classify(input pipe_t x);
    pipe_t            y;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    y      = x;
    ea     = x.a[W-2 -: EXP_W];
    eb     = x.b[W-2 -: EXP_W];
    ma     = x.a[MAN_W-1:0];
    mb     = x.b[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (ma == '0);
    b_inf  = (&eb) && (ma == '0 ? mb == '0 : mb == '0);
    a_nan  = (&ea) && (|ma);
    b_nan  = (&eb) && (|mb);
    y.sign         = x.a[W-1] ^ x.b[W-1];
    y.special      = 1'b1;
    y.spec_invalid = 1'b0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      y.spec_res     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      y.spec_invalid = 1'b1;
    end else if (a_inf || b_inf) begin
      y.spec_res = {y.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      y.spec_res = {y.sign, {(W-1){1'b0}}};
    end else begin
      y.special  = 1'b0;
      y.spec_res = '0;
    end
    y.prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
    y.expo = $signed({2'b00, ea}) + $signed({2'b00, eb}) - EXP_BIAS;
    return y;
  endfunction

  // Phase 2: normalise the product, extract mantissa, guard and sticky.
  function automatic pipe_t f_normalise(input pipe_t x);
    pipe_t y;
    y = x;
    if (x.prod[PW-1]) begin
      y.expo = x.expo + EXP_ONE;
    end else begin
      y.prod = x.prod << 1;
    end
    y.man    = y.prod[PW-2 -: MAN_W];
    y.guard  = y.prod[MAN_W];
    y.sticky = |y.prod[MAN_W-1:0];
    return y;
  endfunction

  // Phase 3: round, range-check and pack the result with its flags.
  function automatic pipe_t f_round(input pipe_t x);
    pipe_t                 y;
    logic                  up;
    logic [MAN_W:0]        man_r;
    logic signed [EW2-1:0] e;
    logic                  inexact;
    y       = x;
    up      = (RNE != 0) && x.guard && (x.sticky || x.man[0]);
    man_r   = {1'b0, x.man} + {{MAN_W{1'b0}}, up};
    // A carry out of the mantissa leaves man_r[MAN_W-1:0] at zero already.
    e       = x.expo + $signed({{(EW2-1){1'b0}}, man_r[MAN_W]});
    inexact = x.guard | x.sticky;
    if (x.special) begin
      y.res = x.spec_res;
      y.flg = {x.spec_invalid, 3'b000};
    end else if (e >= EXP_SAT) begin
      y.res = {x.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      y.flg = 4'b0101;
    end else if (e <= 0) begin
      y.res = {x.sign, {(W-1){1'b0}}};
      y.flg = 4'b0011;
    end else begin
      y.res = {x.sign, e[EXP_W-1:0], man_r[MAN_W-1:0]};
      y.flg = {3'b000, inexact};
    end
    return y;
  endfunction

  pipe_t stage_q [0:STAGES-1];
  pipe_t stage_d [0:STAGES-1];
  logic  stall;

  assign stall     = stage_q[STAGES-1].valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = stage_q[STAGES-1].valid;
  assign result    = stage_q[STAGES-1].res;
  assign out_tag   = stage_q[STAGES-1].tag;
  assign flags     = stage_q[STAGES-1].flg;

  // Next value of every slot: previous slot (or the input port) passed
  // through whichever phases are mapped onto this slot.
  always_comb begin
    pipe_t x;
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: combinational temporaries use blocking '=' and get a default
      // every pass, so no latch is inferred; registers below use '<='.
      x = '0;
      if (k == 0) begin
        x.valid = in_valid;
        x.tag   = in_tag;
        x.a     = a;
        x.b     = b;
      end else begin
        x = stage_q[(k > 0) ? k - 1 : 0];
      end
      if (k == PH1_SLOT) x = f_classify(x);
      if (k == PH2_SLOT) x = f_normalise(x);
      if (k == PH3_SLOT) x = f_round(x);
      stage_d[k] = x;
    end
  end

  // Global-stall pipeline: every slot advances together when not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are reset in full, not just their valid bits, because
      // result, out_tag and flags must read zero during and after reset.
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

endmodule
